sync_fifo_param: RTL and testbench

Parametrised synchronous FIFO: configurable data width and depth, an occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. It is the general-purpose successor to the fixed 16x8 FIFO buffer. It is intended as the standard single-clock buffer between producer and consumer blocks in the memory subsystem. Reads are registered (one-cycle latency) and qualified by a valid strobe.

---
 rtl/sync_fifo_param.sv | 118 +++++++++++
 tb/tb_sync_fifo_param.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered read port, occupancy count,
// programmable almost-full/almost-empty thresholds and sticky error flags.
module sync_fifo_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     WR,
    input  logic [DATA_WIDTH-1:0]    dataIn,
    input  logic                     RD,
    input  logic                     CLR_ERR,
    output logic [DATA_WIDTH-1:0]    dataOut,
    output logic                     dataValid,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic                     ALMOST_FULL,
    output logic                     ALMOST_EMPTY,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     OVERFLOW,
    output logic                     UNDERFLOW
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C   = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C  = CW'(AEMPTY_THRESH);
    localparam logic [CW-1:0] COUNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wrPtr;
    logic [AW-1:0]         rdPtr;
    logic [CW-1:0]         countNext;
    logic                  wrAcc;
    logic                  rdAcc;
    logic                  ovfSet;
    logic                  udfSet;

    // A read in the same cycle frees a slot, so a full FIFO still takes a write alongside it.
    always_comb begin
        wrAcc     = WR && (!FULL || RD);
        rdAcc     = RD && !EMPTY;
        ovfSet    = WR && FULL && !RD;
        udfSet    = RD && EMPTY;
        countNext = count;
        if (wrAcc && !rdAcc) begin
            countNext = count + COUNT_ONE;
        end else if (rdAcc && !wrAcc) begin
            countNext = count - COUNT_ONE;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst_n && wrAcc) begin
            mem[wrPtr] <= dataIn;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            dataOut   <= '0;
            dataValid <= 1'b0;
        end else begin
            dataValid <= rdAcc;
            if (wrAcc) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (rdAcc) begin
                dataOut <= mem[rdPtr];
                rdPtr   <= rdPtr + PTR_ONE;
            end
        end
    end

    // Status flags are registered from the next count so they always agree with count.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            count        <= '0;
            FULL         <= 1'b0;
            EMPTY        <= 1'b1;
            ALMOST_FULL  <= 1'b0;
            ALMOST_EMPTY <= 1'b1;
        end else begin
            count        <= countNext;
            FULL         <= (countNext == DEPTH_C);
            EMPTY        <= (countNext == '0);
            ALMOST_FULL  <= (countNext >= AFULL_C);
            ALMOST_EMPTY <= (countNext <= AEMPTY_C);
        end
    end

    // A new error on the same edge as CLR_ERR keeps its flag set.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            if (ovfSet) begin
                OVERFLOW <= 1'b1;
            end else if (CLR_ERR) begin
                OVERFLOW <= 1'b0;
            end
            if (udfSet) begin
                UNDERFLOW <= 1'b1;
            end else if (CLR_ERR) begin
                UNDERFLOW <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DEPTH=16, DATA_WIDTH=8): a vector table
// for fill/overflow/drain plus a queue model and read-data scoreboard for the rest.
module tb_sync_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int NVEC  = 34;

    logic          Clk;
    logic          Rst_n;
    logic          WR;
    logic          RD;
    logic          CLR_ERR;
    logic [DW-1:0] dataIn;
    logic [DW-1:0] dataOut;
    logic          dataValid;
    logic          FULL;
    logic          EMPTY;
    logic          ALMOST_FULL;
    logic          ALMOST_EMPTY;
    logic [4:0]    count;
    logic          OVERFLOW;
    logic          UNDERFLOW;

    typedef struct {
        logic          wr;
        logic          rd;
        logic          clr;
        logic [DW-1:0] din;
        logic [4:0]    expCount;
        logic          expFull;
        logic          expEmpty;
        logic          expAf;
        logic          expOvf;
        logic          expValid;
        logic [DW-1:0] expData;
    } vec_t;

    vec_t          vecs [NVEC];
    int            checkCount = 0;
    int            errCount   = 0;
    logic [DW-1:0] modelQ [$];
    logic [DW-1:0] expQ [$];
    logic          mOvf;
    logic          mUdf;
    logic          mValid;
    logic [DW-1:0] lastOut;

    sync_fifo_param #(
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .AFULL_THRESH(DEPTH - 2),
        .AEMPTY_THRESH(2)
    ) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .WR(WR),
        .dataIn(dataIn),
        .RD(RD),
        .CLR_ERR(CLR_ERR),
        .dataOut(dataOut),
        .dataValid(dataValid),
        .FULL(FULL),
        .EMPTY(EMPTY),
        .ALMOST_FULL(ALMOST_FULL),
        .ALMOST_EMPTY(ALMOST_EMPTY),
        .count(count),
        .OVERFLOW(OVERFLOW),
        .UNDERFLOW(UNDERFLOW)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        modelQ.delete();
        expQ.delete();
        mOvf    = 1'b0;
        mUdf    = 1'b0;
        mValid  = 1'b0;
        lastOut = '0;
    endtask

    // Updates the queue model from pre-edge state, drives the inputs and advances one edge.
    task automatic applyStimulus(input logic wr, input logic rd, input logic clr, input logic [DW-1:0] din);
        logic full;
        logic empty;
        logic wAcc;
        logic rAcc;
        full  = (modelQ.size() == DEPTH);
        empty = (modelQ.size() == 0);
        wAcc  = wr && (!full || rd);
        rAcc  = rd && !empty;
        if (rAcc) expQ.push_back(modelQ.pop_front());
        if (wAcc) modelQ.push_back(din);
        mOvf   = (wr && full && !rd) ? 1'b1 : (clr ? 1'b0 : mOvf);
        mUdf   = (rd && empty) ? 1'b1 : (clr ? 1'b0 : mUdf);
        mValid = rAcc;
        WR      = wr;
        RD      = rd;
        CLR_ERR = clr;
        dataIn  = din;
        @(posedge Clk);
        #1;
        WR      = 1'b0;
        RD      = 1'b0;
        CLR_ERR = 1'b0;
    endtask

    task automatic applyReset(input logic wr, input logic rd);
        Rst_n  = 1'b0;
        WR     = wr;
        RD     = rd;
        dataIn = 8'h3C;
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        WR    = 1'b0;
        RD    = 1'b0;
        modelReset();
    endtask

    task automatic checkOutput();
        check("count", count, modelQ.size());
        check("FULL", FULL, modelQ.size() == DEPTH);
        check("EMPTY", EMPTY, modelQ.size() == 0);
        check("ALMOST_FULL", ALMOST_FULL, modelQ.size() >= DEPTH - 2);
        check("ALMOST_EMPTY", ALMOST_EMPTY, modelQ.size() <= 2);
        check("OVERFLOW", OVERFLOW, mOvf);
        check("UNDERFLOW", UNDERFLOW, mUdf);
        check("dataValid", dataValid, mValid);
        if (mValid) begin
            if (expQ.size() == 0) begin
                checkCount++;
                errCount++;
                $display("[TB] FAIL scoreboard: got read data %0h expected no pending read", dataOut);
            end else begin
                lastOut = expQ.pop_front();
                check("dataOut", dataOut, lastOut);
            end
        end else begin
            check("dataHold", dataOut, lastOut);
        end
    endtask

    task automatic checkVector(input int idx);
        check($sformatf("vec%0d.count", idx), count, vecs[idx].expCount);
        check($sformatf("vec%0d.FULL", idx), FULL, vecs[idx].expFull);
        check($sformatf("vec%0d.EMPTY", idx), EMPTY, vecs[idx].expEmpty);
        check($sformatf("vec%0d.ALMOST_FULL", idx), ALMOST_FULL, vecs[idx].expAf);
        check($sformatf("vec%0d.OVERFLOW", idx), OVERFLOW, vecs[idx].expOvf);
        check($sformatf("vec%0d.dataValid", idx), dataValid, vecs[idx].expValid);
        if (vecs[idx].expValid) check($sformatf("vec%0d.dataOut", idx), dataOut, vecs[idx].expData);
    endtask

    initial begin
        Rst_n   = 1'b0;
        WR      = 1'b0;
        RD      = 1'b0;
        CLR_ERR = 1'b0;
        dataIn  = '0;
        modelReset();

        // Fill with 0..15, two rejected writes, then drain 16 words.
        for (int i = 0; i < NVEC; i++) begin
            vecs[i].clr = 1'b0;
            if (i < 16) begin
                vecs[i].wr       = 1'b1;
                vecs[i].rd       = 1'b0;
                vecs[i].din      = 8'(i);
                vecs[i].expCount = 5'(i + 1);
                vecs[i].expFull  = (i == 15);
                vecs[i].expEmpty = 1'b0;
                vecs[i].expAf    = (i + 1 >= 14);
                vecs[i].expOvf   = 1'b0;
                vecs[i].expValid = 1'b0;
                vecs[i].expData  = '0;
            end else if (i < 18) begin
                vecs[i].wr       = 1'b1;
                vecs[i].rd       = 1'b0;
                vecs[i].din      = 8'(i);
                vecs[i].expCount = 5'd16;
                vecs[i].expFull  = 1'b1;
                vecs[i].expEmpty = 1'b0;
                vecs[i].expAf    = 1'b1;
                vecs[i].expOvf   = 1'b1;
                vecs[i].expValid = 1'b0;
                vecs[i].expData  = '0;
            end else begin
                vecs[i].wr       = 1'b0;
                vecs[i].rd       = 1'b1;
                vecs[i].din      = '0;
                vecs[i].expCount = 5'(15 - (i - 18));
                vecs[i].expFull  = 1'b0;
                vecs[i].expEmpty = (i == NVEC - 1);
                vecs[i].expAf    = (15 - (i - 18) >= 14);
                vecs[i].expOvf   = 1'b1;
                vecs[i].expValid = 1'b1;
                vecs[i].expData  = 8'(i - 18);
            end
        end

        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        checkOutput();

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
            checkVector(i);
            checkOutput();
        end

        // Reads at empty, a clear that coincides with a new underflow, then a clean clear.
        repeat (2) begin
            applyStimulus(1'b0, 1'b1, 1'b0, '0);
            checkOutput();
        end
        applyStimulus(1'b0, 1'b1, 1'b1, '0);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b1, '0);
        checkOutput();
        check("errClearedOvf", OVERFLOW, 1'b0);
        check("errClearedUdf", UNDERFLOW, 1'b0);

        // Pointer wrap-around.
        for (int i = 0; i < 10; i++) begin applyStimulus(1'b1, 1'b0, 1'b0, 8'(100 + i)); checkOutput(); end
        for (int i = 0; i < 10; i++) begin applyStimulus(1'b0, 1'b1, 1'b0, '0); checkOutput(); end
        for (int i = 0; i < 12; i++) begin applyStimulus(1'b1, 1'b0, 1'b0, 8'(200 + i)); checkOutput(); end
        for (int i = 0; i < 12; i++) begin applyStimulus(1'b0, 1'b1, 1'b0, '0); checkOutput(); end

        // Simultaneous read/write while full, drain, then while empty.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
            checkOutput();
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
            checkOutput();
        end
        for (int i = 0; i < DEPTH; i++) begin applyStimulus(1'b0, 1'b1, 1'b0, '0); checkOutput(); end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
            checkOutput();
        end
        check("rdwrAtEmptyUdf", UNDERFLOW, 1'b1);
        check("rdwrAtEmptyCount", count, 5'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, '0);
        checkOutput();

        // Reset with count=7 while WR and RD are both high.
        for (int i = 0; i < 7; i++) begin applyStimulus(1'b1, 1'b0, 1'b0, 8'(50 + i)); checkOutput(); end
        check("preResetCount", count, 5'd7);
        applyReset(1'b1, 1'b1);
        checkOutput();
        check("resetEMPTY", EMPTY, 1'b1);
        check("resetDataOut", dataOut, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hA5);
        checkOutput();
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        checkOutput();
        check("postResetRead", dataOut, 8'hA5);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
